uart_rx_buffered: RTL and testbench
===================================

Name: uart_rx_buffered

Overview:
- Receive end of the team's 8N1 UART link: a 16x-oversampled serial receiver with start-bit validation and framing-error detection, followed by a small first-word-fall-through (FWFT) receive FIFO.
- Sits between the external rx pin and byte-consuming logic; pairs with the existing transmitter.
- Consumer drains bytes with a rd_en / rx_empty handshake.

Parameters:
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD, 9600: line rate in bits/s.
- OVERSAMPLE, 16: sample ticks per bit. Fixed at 16; other values unsupported.
- FIFO_DEPTH, 4: receive FIFO entries. Power of two, minimum 2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  serial input, asynchronous to clk, idle high.
- rd_en  in  1  pop FIFO head on this clock edge.
- byte  out  8  FIFO head. Valid while rx_empty=0; reads 8'h00 when empty.
- rx_empty  out  1  FIFO holds no bytes.
- rx_full  out  1  FIFO holds FIFO_DEPTH bytes.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: valid byte dropped because FIFO was full.
- parity_err  out  1  one-cycle pulse: parity mismatch (see Optional Feature).

Behaviour:
- Reset (rst=0, async) values:
  - byte=0, rx_empty=1, rx_full=0, all error pulses 0.
  - FSM to IDLE; FIFO pointers and count cleared.
  - Synchronizer flops preset to 1, so no false start on release.
- rx passes a 2-flop synchronizer; all sampling uses the synchronized value.
- Tick generator: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer-truncated (651 at defaults). Emits a one-clock tick every DIV clocks. Restarts at 0 on IDLE->START, aligning ticks to the falling edge.
- FSM, 4-bit tick counter per bit:
  - IDLE: synchronized rx=0 -> START.
  - START: on 8th tick (mid-bit), rx=0 -> DATA; rx=1 -> IDLE (glitch rejected, nothing reported).
  - DATA: sample each 16 ticks at mid-bit, LSB first, into shift register. After bit 7 -> STOP.
  - STOP: at mid-bit:
    - rx=1: push byte to FIFO, go IDLE.
    - rx=0: frame_err pulses, byte discarded, go WAIT.
  - WAIT: stay until synchronized rx=1, then IDLE. A held-low break line generates exactly one frame_err.
- Push timing: push occurs on the clock after the stop-bit mid-sample. rx_empty falls on that same edge.
- FIFO is FWFT: byte always shows the head entry.
- Handshake rules:
  - rd_en with rx_empty=0 pops on the edge; next head appears the following cycle.
  - rd_en with rx_empty=1 is ignored.
- Push while full with no simultaneous pop: byte dropped, overrun pulses one cycle, FIFO contents unchanged.
- Push and pop on the same edge while full: both proceed, no overrun, rx_full stays 1.
- Push and pop on the same edge with count=1: count stays 1, new byte becomes head.
- Pointers wrap modulo FIFO_DEPTH. Count register is log2(FIFO_DEPTH)+1 bits.
- Reset mid-frame: partial byte abandoned, FIFO emptied. Next full frame after rx returns idle is received normally.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: an even-parity bit is sampled after bit 7, before STOP.
  - Mismatch: parity_err pulses one cycle, the byte is not pushed, and STOP is still checked. A frame with both errors pulses both outputs in the same cycle.
- Undefined:
  - Frame is 8N1; parity_err is tied to 0.
  - No parity state or logic is synthesized.

Test Plan:
- Send 0xF0 at 9600 baud (10416 clk/bit) -> rx_empty falls about 9.5 bit times after start edge, byte=0xF0; one rd_en pulse -> rx_empty=1, byte=0x00.
- Low glitch of 3000 clks on idle rx -> no push, no error pulses, FSM back in IDLE; following 0x5A received correctly.
- Send 0x55 with stop bit forced low, hold rx low 2 bit times -> exactly one frame_err pulse, FIFO empty. Then rx high 1 bit, send 0xA5 -> byte=0xA5.
- Send 0x01..0x05 back-to-back without reading (FIFO_DEPTH=4):
  - rx_full=1 after 0x04.
  - overrun pulses once at 0x05.
  - Four reads return 0x01,0x02,0x03,0x04, then rx_empty=1.
- Drop rst low at bit 4 of a 0x3C frame -> outputs take reset values, no push. Next 0x3C frame -> byte=0x3C.
- With UART_RX_PARITY_EN:
  - 0x07 with parity bit 1 -> accepted.
  - 0x07 with parity bit 0 -> parity_err pulse, FIFO stays empty.

Source files
------------

// File: rtl/uart_rx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_buffered
// Brief    : 16x-oversampled 8N1 UART receiver feeding a small FWFT receive
//            FIFO. Define UART_RX_PARITY_EN to receive 8E1 frames instead.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_buffered #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] rx_byte,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int c_div_raw = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int c_div     = (c_div_raw > 0) ? c_div_raw : 1;
    localparam int c_div_w   = (c_div > 1) ? $clog2(c_div) : 1;
    localparam int c_aw      = $clog2(FIFO_DEPTH);

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);
    localparam logic [c_aw:0]      c_full_cnt = (c_aw + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_WAIT   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4,
        S_WAIT  = 3'd5
    } state_t;
`endif

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_sync;
    logic                 w_rx;
    logic [c_div_w-1:0]   r_div_cnt;
    logic                 w_tick;
    logic [3:0]           r_tick_cnt;
    logic                 w_mid;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_shift;
    logic                 r_push;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic                 w_start;
    logic                 w_bit_clr;
    logic                 w_shift;
    logic                 w_push_req;
    logic                 w_ferr;

    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]      r_wr_ptr;
    logic [c_aw-1:0]      r_rd_ptr;
    logic [c_aw:0]        r_count;
    logic                 w_pop;
    logic                 w_wr;

    // Preset to idle-high so releasing reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    assign w_rx   = r_sync[1];
    assign w_tick = (r_div_cnt == c_div_last);
    assign w_mid  = w_tick && (r_tick_cnt == 4'd15);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;
    logic w_par_sample;
    logic w_perr;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_bit_clr   = 1'b0;
        w_shift     = 1'b0;
        w_push_req  = 1'b0;
        w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_sample = 1'b0;
        w_perr       = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_rx) begin
                    w_state_nxt = S_START;
                    w_start     = 1'b1;
                end
            end
            S_START: begin
                // Eighth tick lands mid start bit; a high line here was a glitch.
                if (w_tick && (r_tick_cnt == 4'd7)) begin
                    if (w_rx) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_bit_clr   = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_mid) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_mid) begin
                    w_par_sample = 1'b1;
                    w_state_nxt  = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_mid) begin
`ifdef UART_RX_PARITY_EN
                    w_perr     = r_par_bad;
                    w_push_req = w_rx && !r_par_bad;
`else
                    w_push_req = w_rx;
`endif
                    if (w_rx) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (w_rx) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt   <= '0;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_div_cnt <= (w_start || w_tick) ? '0 : r_div_cnt + 1'b1;

            if (w_start || w_bit_clr) begin
                r_tick_cnt <= '0;
            end else if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + 4'd1;
            end

            if (w_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_shift) begin
                r_shift <= {w_rx, r_shift[7:1]};
            end

            r_push      <= w_push_req;
            r_frame_err <= w_ferr;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the received parity bit must equal the XOR of the data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_start) begin
                r_par_bad <= 1'b0;
            end else if (w_par_sample) begin
                r_par_bad <= (w_rx != ^r_shift);
            end
            r_parity_err <= w_perr;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    // Receive FIFO: a pop frees a slot in the same edge, so push-while-full
    // only drops the byte when nothing is being read.
    assign w_pop = rd_en && (r_count != '0);
    assign w_wr  = r_push && ((r_count != c_full_cnt) || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overrun <= r_push && !w_wr;
        end
    end

    assign rx_empty  = (r_count == '0);
    assign rx_full   = (r_count == c_full_cnt);
    assign rx_byte   = rx_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_buffered
// Brief    : Randomized frames checked against a queue model of the receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_buffered;

    localparam int CLK_FREQ = 640000;
    localparam int BAUD     = 10000;
    localparam int DEPTH    = 4;
    localparam int c_bit    = (CLK_FREQ / (BAUD * 16)) * 16;
`ifdef UART_RX_PARITY_EN
    localparam bit c_par = 1'b1;
`else
    localparam bit c_par = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       rx    = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] rx_byte;
    logic       rx_empty;
    logic       rx_full;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    uart_rx_buffered #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rd_en      (rd_en),
        .rx_byte    (rx_byte),
        .rx_empty   (rx_empty),
        .rx_full    (rx_full),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         cyc       = 0;
    int         start_cyc = 0;
    int         fall_cyc  = -1;
    int         n_ferr    = 0;
    int         n_ovr     = 0;
    int         n_perr    = 0;
    logic       prev_empty = 1'b1;
    logic [7:0] model_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_err === 1'b1)  n_ferr++;
        if (overrun === 1'b1)    n_ovr++;
        if (parity_err === 1'b1) n_perr++;
        if (prev_empty && (rx_empty === 1'b0)) fall_cyc = cyc;
        prev_empty = rx_empty;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (c_bit) @(negedge clk);
    endtask

    // Start, 8 data bits LSB first, optional even parity, stop; a bad stop
    // bit can be stretched into a break by hold_bits extra low bit times.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                              input logic par_ok, input int hold_bits);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (c_par) drive_bit((^d) ^ !par_ok);
        drive_bit(stop_ok);
        if (!stop_ok) repeat (hold_bits) drive_bit(1'b0);
        rx = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check({tag, " rx_empty"}, rx_empty, model_q.size() == 0);
        check({tag, " rx_full"},  rx_full,  model_q.size() == DEPTH);
        check({tag, " byte"},     rx_byte,  (model_q.size() != 0) ? model_q[0] : 8'h00);
    endtask

    task automatic frame_and_check(input string tag, input logic [7:0] d, input logic stop_ok,
                                   input logic par_ok, input int hold_bits);
        int f0;
        int o0;
        int p0;
        bit good;
        bit drop;
        f0   = n_ferr;
        o0   = n_ovr;
        p0   = n_perr;
        good = stop_ok && (par_ok || !c_par);
        drop = good && (model_q.size() == DEPTH);
        send_frame(d, stop_ok, par_ok, hold_bits);
        idle(8);
        if (good && !drop) model_q.push_back(d);
        check({tag, " frame_err pulses"},  n_ferr - f0, {31'd0, !stop_ok});
        check({tag, " overrun pulses"},    n_ovr - o0,  {31'd0, drop});
        check({tag, " parity_err pulses"}, n_perr - p0, {31'd0, c_par && !par_ok});
        check_state(tag);
    endtask

    task automatic pop_check(input string tag);
        check({tag, " head"}, rx_byte, model_q[0]);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        void'(model_q.pop_front());
        check_state({tag, " after pop"});
    endtask

    task automatic pop_empty(input string tag);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check_state({tag, " empty pop"});
    endtask

    task automatic drain(input string tag);
        while (model_q.size() != 0) pop_check(tag);
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int o0;
        int p0;
        int lat;
        int nom;

        // Reset values
        idle(3);
        check("reset rx_empty",   rx_empty,   1'b1);
        check("reset rx_full",    rx_full,    1'b0);
        check("reset byte",       rx_byte,    8'h00);
        check("reset frame_err",  frame_err,  1'b0);
        check("reset overrun",    overrun,    1'b0);
        check("reset parity_err", parity_err, 1'b0);
        rst = 1'b1;
        idle(10);

        // Single byte, latency of roughly 9.5 bit times from the start edge
        fall_cyc = -1;
        frame_and_check("f0", 8'hF0, 1'b1, 1'b1, 0);
        lat = fall_cyc - start_cyc;
        nom = c_bit * (9 + (c_par ? 1 : 0)) + c_bit / 2;
        check("f0 latency in window", (lat >= nom - 2) && (lat <= nom + 12), 1'b1);
        pop_check("f0");

        // Short low glitch on an idle line
        f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
        rx = 1'b0;
        idle(12);
        rx = 1'b1;
        idle(2 * c_bit);
        check("glitch frame_err", n_ferr - f0, 0);
        check("glitch overrun",   n_ovr - o0,  0);
        check("glitch parity",    n_perr - p0, 0);
        check_state("glitch");
        frame_and_check("5a", 8'h5A, 1'b1, 1'b1, 0);
        drain("5a");

        // Bad stop bit stretched into a break: a single frame_err
        frame_and_check("break", 8'h55, 1'b0, 1'b1, 2);
        idle(c_bit);
        frame_and_check("a5", 8'hA5, 1'b1, 1'b1, 0);
        drain("a5");
        pop_empty("after a5");

        // Overflow: fifth byte is dropped with one overrun pulse
        for (int i = 1; i <= 5; i++) frame_and_check("fill", 8'(i), 1'b1, 1'b1, 0);
        drain("fill");

        // Reset in the middle of a frame with a byte already queued
        frame_and_check("pre rst", 8'h11, 1'b1, 1'b1, 0);
        rx = 1'b0;
        repeat (c_bit) @(negedge clk);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h3C >> i));
        rx = 1'b0;
        idle(c_bit / 2);
        rst = 1'b0;
        #1;
        model_q.delete();
        check("midrst rx_empty",  rx_empty,  1'b1);
        check("midrst rx_full",   rx_full,   1'b0);
        check("midrst byte",      rx_byte,   8'h00);
        check("midrst frame_err", frame_err, 1'b0);
        check("midrst overrun",   overrun,   1'b0);
        idle(2);
        rx = 1'b1;
        idle(2);
        rst = 1'b1;
        idle(c_bit);
        check_state("after rst");
        frame_and_check("3c", 8'h3C, 1'b1, 1'b1, 0);
        drain("3c");

        if (c_par) begin
            frame_and_check("par good", 8'h07, 1'b1, 1'b1, 0);
            frame_and_check("par bad",  8'h07, 1'b1, 1'b0, 0);
            frame_and_check("par+stop", 8'h33, 1'b0, 1'b0, 0);
            drain("par");
        end

        // Randomized traffic with occasional line errors and reads
        for (int n = 0; n < 35; n++) begin
            logic [7:0] d;
            logic       s_ok;
            logic       p_ok;
            int         k;
            d    = 8'($urandom);
            s_ok = ($urandom_range(0, 7) != 0);
            p_ok = ($urandom_range(0, 7) != 0);
            frame_and_check("rand", d, s_ok, p_ok, 0);
            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) begin
                if (model_q.size() != 0) pop_check("rand");
                else pop_empty("rand");
            end
        end
        drain("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
